// File: rtl/repairval_partner_responder.sv
// repairval_partner_responder
// Partner-side responder for the MBINIT.REPAIRVAL sideband handshake.
// It answers init/result/done requests and checks the valid-lane pattern
// 8'b11110000 while in CHECK_PATTERN.
// Optional build macro REPAIRVAL_PARTNER_TIMEOUT_EN adds a per-state watchdog.
// That watchdog and its TIMEOUT_CYC parameter exist only when the macro is defined.
module repairval_partner_responder #(
  parameter int CNT_W          = 8,
  parameter int ITER_NUM       = 128,
  parameter int PASS_THRESHOLD = 16
`ifdef REPAIRVAL_PARTNER_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYC = 24'd8000000
`endif
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_REPAIRCLK_end,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_VAL_Rx,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_VAL_Result_logged,
  output logic       o_VAL_Checker_En,
  output logic       o_train_error_req,
  output logic       o_MBINIT_REPAIRVAL_Partner_end
);

  localparam logic [CNT_W-1:0] LP_ITER   = CNT_W'(ITER_NUM);
  localparam logic [CNT_W-1:0] LP_THRESH = CNT_W'(PASS_THRESHOLD);
  localparam logic [7:0]       LP_PATTERN = 8'b1111_0000;

  typedef enum logic [3:0] {
    S_IDLE             = 4'd0,
    S_WAIT_INIT_REQ    = 4'd1,
    S_WAIT_BUSY_INIT   = 4'd2,
    S_SEND_INIT_RESP   = 4'd3,
    S_CHECK_PATTERN    = 4'd4,
    S_WAIT_BUSY_RESULT = 4'd5,
    S_SEND_RESULT_RESP = 4'd6,
    S_WAIT_DONE_REQ    = 4'd7,
    S_WAIT_BUSY_DONE   = 4'd8,
    S_SEND_DONE_RESP   = 4'd9,
    S_COMPLETE         = 4'd10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_proto_err;
  logic             w_timeout;
  logic             w_init_req;
  logic             w_result_req;
  logic             w_done_req;
  logic [3:0]       w_tx_next;
  logic             w_valid_next;
  logic             w_chk_en_next;
  logic             w_end_next;
  logic             w_chk_clear;
  logic             w_chk_active;
  logic             w_latch_result;
  logic [7:0]       w_byte;
  logic             r_started;
  logic [6:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_iter_cnt;
  logic [CNT_W-1:0] r_ok_cnt;
  logic             r_result;

  assign w_init_req   = i_msg_valid && (i_Rx_SbMessage == 4'd1);
  assign w_result_req = i_msg_valid && (i_Rx_SbMessage == 4'd3);
  assign w_done_req   = i_msg_valid && (i_Rx_SbMessage == 4'd5);

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; abort (REPAIRCLK_end low) overrides everything
  always_comb begin
    w_next_state = r_state;
    w_proto_err  = 1'b0;
    case (r_state)
      S_IDLE:             if (i_REPAIRCLK_end) w_next_state = S_WAIT_INIT_REQ;
      S_WAIT_INIT_REQ: begin
        if (w_init_req) w_next_state = S_WAIT_BUSY_INIT;
        else if (w_result_req || w_done_req) begin
          w_proto_err  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_BUSY_INIT:   if (!i_Busy_SideBand) w_next_state = S_SEND_INIT_RESP;
      S_SEND_INIT_RESP:   if (i_falling_edge_busy) w_next_state = S_CHECK_PATTERN;
      S_CHECK_PATTERN: begin
        if (w_result_req) w_next_state = S_WAIT_BUSY_RESULT;
        else if (w_init_req) begin
          w_proto_err  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_BUSY_RESULT: if (!i_Busy_SideBand) w_next_state = S_SEND_RESULT_RESP;
      S_SEND_RESULT_RESP: if (i_falling_edge_busy) w_next_state = S_WAIT_DONE_REQ;
      S_WAIT_DONE_REQ: begin
        if (w_done_req) w_next_state = S_WAIT_BUSY_DONE;
        else if (w_init_req) begin
          w_proto_err  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_BUSY_DONE:   if (!i_Busy_SideBand) w_next_state = S_SEND_DONE_RESP;
      S_SEND_DONE_RESP:   if (i_falling_edge_busy) w_next_state = S_COMPLETE;
      S_COMPLETE: begin
        if (w_init_req) begin
          w_proto_err  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default:            w_next_state = S_IDLE;
    endcase
    if (w_timeout) begin
      w_proto_err  = 1'b1;
      w_next_state = S_IDLE;
    end
    if ((r_state != S_IDLE) && !i_REPAIRCLK_end) begin
      w_proto_err  = 1'b0;
      w_next_state = S_IDLE;
    end
  end

  // Output decode from the state being entered
  always_comb begin
    w_tx_next     = 4'd0;
    w_valid_next  = 1'b0;
    w_chk_en_next = 1'b0;
    w_end_next    = 1'b0;
    case (w_next_state)
      S_SEND_INIT_RESP:   begin w_valid_next = 1'b1; w_tx_next = 4'd2; end
      S_SEND_RESULT_RESP: begin w_valid_next = 1'b1; w_tx_next = 4'd4; end
      S_SEND_DONE_RESP:   begin w_valid_next = 1'b1; w_tx_next = 4'd6; end
      S_CHECK_PATTERN:    w_chk_en_next = 1'b1;
      S_COMPLETE:         w_end_next    = 1'b1;
      default:            ;
    endcase
  end

  // Output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      o_TX_SbMessage                 <= 4'd0;
      o_ValidOutDatat_Module         <= 1'b0;
      o_VAL_Checker_En               <= 1'b0;
      o_MBINIT_REPAIRVAL_Partner_end <= 1'b0;
      o_train_error_req              <= 1'b0;
    end else begin
      o_TX_SbMessage                 <= w_tx_next;
      o_ValidOutDatat_Module         <= w_valid_next;
      o_VAL_Checker_En               <= w_chk_en_next;
      o_MBINIT_REPAIRVAL_Partner_end <= w_end_next;
      o_train_error_req              <= w_proto_err;
    end
  end

  // Comparator runs only while staying in CHECK_PATTERN, so a bit arriving
  // with result_req is treated as part of the discarded partial iteration.
  assign w_chk_clear    = ((w_next_state == S_CHECK_PATTERN) && (r_state != S_CHECK_PATTERN)) ||
                          (w_next_state == S_IDLE);
  assign w_chk_active   = (r_state == S_CHECK_PATTERN) && (w_next_state == S_CHECK_PATTERN) &&
                          (r_iter_cnt != LP_ITER);
  assign w_latch_result = (r_state == S_CHECK_PATTERN) && (w_next_state == S_WAIT_BUSY_RESULT);
  assign w_byte         = {r_shift, i_VAL_Rx};

  // Pattern comparator: sync on first 1, then compare every 8 bits MSB-first
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_started  <= 1'b0;
      r_shift    <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_iter_cnt <= '0;
      r_ok_cnt   <= '0;
    end else if (w_chk_clear) begin
      r_started  <= 1'b0;
      r_shift    <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_iter_cnt <= '0;
      r_ok_cnt   <= '0;
    end else if (w_chk_active && (r_started || i_VAL_Rx)) begin
      r_started <= 1'b1;
      if (r_bit_cnt == 3'd7) begin
        r_bit_cnt  <= 3'd0;
        r_shift    <= 7'd0;
        r_iter_cnt <= r_iter_cnt + 1'b1;
        if (w_byte == LP_PATTERN) r_ok_cnt <= r_ok_cnt + 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= w_byte[6:0];
      end
    end
  end

  // Pass/fail result: frozen at result_req, dropped on IDLE or new check
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)              r_result <= 1'b0;
    else if (w_chk_clear)    r_result <= 1'b0;
    else if (w_latch_result) r_result <= (r_ok_cnt >= LP_THRESH);
  end

  assign o_VAL_Result_logged = r_result;

`ifdef REPAIRVAL_PARTNER_TIMEOUT_EN
  logic [23:0] r_to_cnt;

  // Watchdog: counts cycles spent in one waiting state
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_to_cnt <= 24'd0;
    else if ((r_state == S_IDLE) || (r_state == S_COMPLETE) || (w_next_state != r_state))
      r_to_cnt <= 24'd0;
    else
      r_to_cnt <= r_to_cnt + 24'd1;
  end

  assign w_timeout = (r_state != S_IDLE) && (r_state != S_COMPLETE) &&
                     (r_to_cnt == (TIMEOUT_CYC - 24'd1));
`else
  assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_repairval_partner_responder.sv
// Directed testbench for repairval_partner_responder.
// With REPAIRVAL_PARTNER_TIMEOUT_EN defined, the watchdog is also exercised
// using a TIMEOUT_CYC of 100.
module tb_repairval_partner_responder;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       i_REPAIRCLK_end;
  logic [3:0] i_Rx_SbMessage;
  logic       i_msg_valid;
  logic       i_Busy_SideBand;
  logic       i_falling_edge_busy;
  logic       i_VAL_Rx;
  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutDatat_Module;
  logic       o_VAL_Result_logged;
  logic       o_VAL_Checker_En;
  logic       o_train_error_req;
  logic       o_MBINIT_REPAIRVAL_Partner_end;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  repairval_partner_responder #(
    .CNT_W(8),
    .ITER_NUM(128),
    .PASS_THRESHOLD(16)
`ifdef REPAIRVAL_PARTNER_TIMEOUT_EN
    , .TIMEOUT_CYC(24'd100)
`endif
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .i_REPAIRCLK_end(i_REPAIRCLK_end),
    .i_Rx_SbMessage(i_Rx_SbMessage),
    .i_msg_valid(i_msg_valid),
    .i_Busy_SideBand(i_Busy_SideBand),
    .i_falling_edge_busy(i_falling_edge_busy),
    .i_VAL_Rx(i_VAL_Rx),
    .o_TX_SbMessage(o_TX_SbMessage),
    .o_ValidOutDatat_Module(o_ValidOutDatat_Module),
    .o_VAL_Result_logged(o_VAL_Result_logged),
    .o_VAL_Checker_En(o_VAL_Checker_En),
    .o_train_error_req(o_train_error_req),
    .o_MBINIT_REPAIRVAL_Partner_end(o_MBINIT_REPAIRVAL_Partner_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_msg(input logic [3:0] code);
    i_msg_valid    = 1'b1;
    i_Rx_SbMessage = code;
    tick();
    i_msg_valid    = 1'b0;
    i_Rx_SbMessage = 4'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      i_VAL_Rx = b[k];
      tick();
    end
    i_VAL_Rx = 1'b0;
  endtask

  // From IDLE (REPAIRCLK_end low) up to the first CHECK_PATTERN cycle
  task automatic enter_check(input string name);
    i_REPAIRCLK_end = 1'b1;
    tick();
    send_msg(4'd1);
    tick();
    chk({name, "_init_resp"}, {27'd0, o_ValidOutDatat_Module, o_TX_SbMessage}, {27'd0, 1'b1, 4'd2});
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    chk({name, "_chk_en"}, {31'd0, o_VAL_Checker_En}, 32'd1);
  endtask

  // result_req, check the response carries the expected result, then abort
  task automatic finish_result(input string name, input logic exp_res);
    send_msg(4'd3);
    tick();
    chk({name, "_result_resp"}, {27'd0, o_ValidOutDatat_Module, o_TX_SbMessage}, {27'd0, 1'b1, 4'd4});
    chk({name, "_result"}, {31'd0, o_VAL_Result_logged}, {31'd0, exp_res});
    chk({name, "_no_err"}, {31'd0, o_train_error_req}, 32'd0);
    $display("TXN %s result=%0d expected=%0d", name, o_VAL_Result_logged, exp_res);
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    i_REPAIRCLK_end = 1'b0;
    tick();
    chk({name, "_abort_clears_result"}, {31'd0, o_VAL_Result_logged}, 32'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    i_REPAIRCLK_end     = 1'b0;
    i_Rx_SbMessage      = 4'd0;
    i_msg_valid         = 1'b0;
    i_Busy_SideBand     = 1'b0;
    i_falling_edge_busy = 1'b0;
    i_VAL_Rx            = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {22'd0, o_TX_SbMessage, o_ValidOutDatat_Module, o_VAL_Result_logged,
        o_VAL_Checker_En, o_train_error_req, o_MBINIT_REPAIRVAL_Partner_end, 1'b0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full pass flow with busy held during WAIT_BUSY_RESULT
    enter_check("pass");
    for (int n = 0; n < 128; n++) send_byte(8'hF0);
    i_Busy_SideBand = 1'b1;
    send_msg(4'd3);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("busy_hold_no_valid", {31'd0, o_ValidOutDatat_Module}, 32'd0);
    end
    i_Busy_SideBand = 1'b0;
    tick();
    chk("pass_result_resp", {27'd0, o_ValidOutDatat_Module, o_TX_SbMessage}, {27'd0, 1'b1, 4'd4});
    chk("pass_result", {31'd0, o_VAL_Result_logged}, 32'd1);
    $display("TXN pass result_resp tx=%0d result=%0d", o_TX_SbMessage, o_VAL_Result_logged);
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    chk("pass_wait_done_idle_tx", {27'd0, o_ValidOutDatat_Module, o_TX_SbMessage}, 32'd0);
    send_msg(4'd5);
    tick();
    chk("pass_done_resp", {27'd0, o_ValidOutDatat_Module, o_TX_SbMessage}, {27'd0, 1'b1, 4'd6});
    $display("TXN pass done_resp tx=%0d", o_TX_SbMessage);
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    chk("pass_partner_end", {31'd0, o_MBINIT_REPAIRVAL_Partner_end}, 32'd1);
    tick();
    chk("pass_partner_end_held", {31'd0, o_MBINIT_REPAIRVAL_Partner_end}, 32'd1);
    i_REPAIRCLK_end = 1'b0;
    tick();
    chk("pass_partner_end_drop", {31'd0, o_MBINIT_REPAIRVAL_Partner_end}, 32'd0);

    // Marginal fail: 15 clean + 113 corrupted
    enter_check("marginal");
    for (int n = 0; n < 15; n++) send_byte(8'hF0);
    for (int n = 0; n < 113; n++) send_byte(8'hE0);
    finish_result("marginal", 1'b0);

    // Threshold edge, with leading idle zeros before the first 1
    enter_check("thresh");
    for (int n = 0; n < 4; n++) begin
      i_VAL_Rx = 1'b0;
      tick();
    end
    for (int n = 0; n < 16; n++) send_byte(8'hF0);
    for (int n = 0; n < 112; n++) send_byte(8'hE0);
    finish_result("thresh", 1'b1);

    // Early result_req after 10 whole iterations plus 3 bits
    enter_check("early");
    for (int n = 0; n < 10; n++) send_byte(8'hF0);
    for (int n = 0; n < 3; n++) begin
      i_VAL_Rx = 1'b1;
      tick();
    end
    i_VAL_Rx = 1'b0;
    finish_result("early", 1'b0);

    // Protocol error: done_req in WAIT_INIT_REQ
    i_REPAIRCLK_end = 1'b1;
    tick();
    send_msg(4'd5);
    chk("done_in_wait_init_err", {31'd0, o_train_error_req}, 32'd1);
    $display("TXN done_req in WAIT_INIT_REQ err=%0d", o_train_error_req);
    tick();
    chk("err_pulse_one_cycle", {31'd0, o_train_error_req}, 32'd0);
    i_REPAIRCLK_end = 1'b0;
    tick();

    // Protocol error: init_req during CHECK_PATTERN
    enter_check("init_in_check");
    send_msg(4'd1);
    chk("init_in_check_err", {31'd0, o_train_error_req}, 32'd1);
    chk("init_in_check_to_idle", {31'd0, o_VAL_Checker_En}, 32'd0);
    $display("TXN init_req in CHECK_PATTERN err=%0d", o_train_error_req);
    i_REPAIRCLK_end = 1'b0;
    tick();

    // Abort by dropping REPAIRCLK_end
    enter_check("abort");
    i_REPAIRCLK_end = 1'b0;
    tick();
    chk("abort_chk_en", {30'd0, o_VAL_Checker_En, o_train_error_req}, 32'd0);

    // Asynchronous reset mid-CHECK_PATTERN
    enter_check("rst");
    send_byte(8'hF0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {22'd0, o_TX_SbMessage, o_ValidOutDatat_Module, o_VAL_Result_logged,
        o_VAL_Checker_En, o_train_error_req, o_MBINIT_REPAIRVAL_Partner_end, 1'b0}, 32'd0);
    $display("TXN async reset chk_en=%0d", o_VAL_Checker_En);
    i_REPAIRCLK_end = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef REPAIRVAL_PARTNER_TIMEOUT_EN
    // Watchdog: no init_req for 100 cycles in WAIT_INIT_REQ
    i_REPAIRCLK_end = 1'b1;
    tick();
    for (int n = 0; n < 99; n++) tick();
    chk("timeout_not_yet", {31'd0, o_train_error_req}, 32'd0);
    tick();
    chk("timeout_err", {31'd0, o_train_error_req}, 32'd1);
    $display("TXN timeout err=%0d", o_train_error_req);
    tick();
    chk("timeout_err_pulse", {31'd0, o_train_error_req}, 32'd0);
    i_REPAIRCLK_end = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repairval_partner_responder.md
Name: repairval_partner_responder

Overview:
- Responder (partner-side) half of the MBINIT.REPAIRVAL handshake.
- Answers sideband init/result/done requests from the remote initiator.
- Checks the received valid-lane training pattern (8'b11110000 per iteration) and reports pass/fail in the result response.
- Sits in MBINIT after the REPAIRCLK responder; drives the shared sideband TX arbiter through the same busy/valid handshake the initiator uses.

Parameters:
- ITER_NUM, 128: pattern iterations compared per run.
- PASS_THRESHOLD, 16: minimum error-free iterations for a pass.
- CNT_W, 8: width of the iteration and error-free counters; must hold ITER_NUM.
- TIMEOUT_CYC, 24'd8000000: timeout in CLK cycles; used only with the optional feature.

Ports:
- CLK, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- i_REPAIRCLK_end, input, 1: REPAIRCLK done; level enable for this block.
- i_Rx_SbMessage, input, 4: decoded received sideband message.
- i_msg_valid, input, 1: i_Rx_SbMessage valid this cycle.
- i_Busy_SideBand, input, 1: sideband TX busy.
- i_falling_edge_busy, input, 1: one-cycle pulse when a TX transfer completes.
- i_VAL_Rx, input, 1: sampled valid-lane bit, one per CLK.
- o_TX_SbMessage, output, 4: message to transmit.
- o_ValidOutDatat_Module, output, 1: TX request valid.
- o_VAL_Result_logged, output, 1: logged pass result, carried in result_resp.
- o_VAL_Checker_En, output, 1: comparator active.
- o_train_error_req, output, 1: one-cycle error pulse.
- o_MBINIT_REPAIRVAL_Partner_end, output, 1: sequence complete (level).

Behaviour:
- Message codes:
  - init_req = 1, init_resp = 2
  - result_req = 3, result_resp = 4
  - done_req = 5, done_resp = 6
- A message is accepted only when i_msg_valid = 1. Any other code is ignored with no state change.
- All outputs are registered and reset to 0.
- Outputs are decoded from next_state; default value is 0 every cycle except where stated below.
- FSM states and transitions:
  - IDLE → WAIT_INIT_REQ when i_REPAIRCLK_end = 1.
  - WAIT_INIT_REQ → WAIT_BUSY_INIT on init_req.
  - WAIT_BUSY_INIT → SEND_INIT_RESP when ~i_Busy_SideBand.
  - SEND_INIT_RESP: o_ValidOutDatat_Module = 1, o_TX_SbMessage = 2. → CHECK_PATTERN on i_falling_edge_busy.
  - CHECK_PATTERN: o_VAL_Checker_En = 1. → WAIT_BUSY_RESULT on result_req. The result is frozen on the cycle result_req is accepted.
  - WAIT_BUSY_RESULT → SEND_RESULT_RESP when ~i_Busy_SideBand.
  - SEND_RESULT_RESP: o_ValidOutDatat_Module = 1, o_TX_SbMessage = 4. → WAIT_DONE_REQ on i_falling_edge_busy.
  - WAIT_DONE_REQ → WAIT_BUSY_DONE on done_req.
  - WAIT_BUSY_DONE → SEND_DONE_RESP when ~i_Busy_SideBand.
  - SEND_DONE_RESP: o_ValidOutDatat_Module = 1, o_TX_SbMessage = 6. → COMPLETE on i_falling_edge_busy.
  - COMPLETE: o_MBINIT_REPAIRVAL_Partner_end = 1. → IDLE when i_REPAIRCLK_end = 0.
- Abort: i_REPAIRCLK_end falling in any non-IDLE state → IDLE next cycle, and clears counters and result.
- Comparator, active only in CHECK_PATTERN:
  - Waits for the first i_VAL_Rx = 1; that bit is bit 7 of iteration 0.
  - Shifts 8 bits MSB-first, compares the byte to 8'b11110000, then increments the iteration count.
  - If the byte matches, also increments the error-free count.
  - Both counters saturate: the iteration count stops at ITER_NUM and further bits are ignored.
  - Counters and shift register clear on entry to CHECK_PATTERN.
- Result: o_VAL_Result_logged = (err_free_cnt >= PASS_THRESHOLD), latched when result_req is accepted.
  - A partial iteration at result_req is discarded.
  - The result is held until IDLE or a new CHECK_PATTERN entry.
- A fail result is reported but not treated as an error. o_train_error_req pulses only for the cases below.
- Unexpected message (result_req/done_req in WAIT_INIT_REQ, init_req in CHECK_PATTERN or later):
  - o_train_error_req pulses for 1 cycle.
  - FSM → IDLE.
  - Exception: init_req during SEND_*/WAIT_BUSY_* states is ignored.
- Simultaneous i_falling_edge_busy and message valid: the transition out of SEND_* takes priority; the message is lost.
- Reset mid-operation: all state, counters and outputs return to 0 asynchronously.

Optional Feature:
- Macro REPAIRVAL_PARTNER_TIMEOUT_EN.
- Defined:
  - A 24-bit counter runs in every non-IDLE, non-COMPLETE state and clears on each state change.
  - Reaching TIMEOUT_CYC pulses o_train_error_req for 1 cycle and forces IDLE.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Full pass flow:
  - Stimulus: REPAIRCLK_end = 1; init_req; 128 clean 11110000 bytes; result_req; done_req; each TX completed with a falling-edge pulse.
  - Response: TX codes 2, 4, 6 in order; o_VAL_Result_logged = 1; Partner_end = 1 until REPAIRCLK_end drops.
- Marginal fail: 15 clean + 113 corrupted iterations → o_VAL_Result_logged = 0 in result_resp; no o_train_error_req.
- Threshold edge: exactly 16 clean iterations → result 1.
- Early result_req after 10 whole iterations plus 3 bits → counts frozen at 10; result 0.
- Protocol errors:
  - done_req in WAIT_INIT_REQ → o_train_error_req 1-cycle pulse, FSM to IDLE.
  - Busy held high while in WAIT_BUSY_RESULT → no o_ValidOutDatat_Module until busy clears.
- Timeout (macro on, TIMEOUT_CYC = 100): no init_req for 100 cycles → o_train_error_req pulse, FSM to IDLE.
- Async reset mid-CHECK_PATTERN → all outputs 0 immediately.
